// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares a single external memory port between instruction fetch
//             and the MEM-stage data access. One transaction is in flight at a
//             time. The memory side is a register slice that is latched when
//             the request is granted. Each requester gets its own one-cycle ack
//             and its own read-data register. Combinational stall outputs
//             freeze the pipeline while a requester waits.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int DM_STREAK_MAX = 4,
  parameter int TIMEOUT_CYC   = 255
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  // data access requester
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_ctrl,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  // external memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_ctrl,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  // pipeline control / status
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err_timeout
);

  localparam int STREAK_W = $clog2(DM_STREAK_MAX + 1);
  localparam int TMR_W    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(DM_STREAK_MAX);
  localparam logic [STREAK_W-1:0] STREAK_ONE  = STREAK_W'(1);
  localparam logic [TMR_W-1:0]    TMR_LAST    = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0]    TMR_FULL    = TMR_W'(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0]    TMR_ONE     = TMR_W'(1);
  localparam logic [2:0]          CTRL_WORD   = 3'b000;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_IF_BUSY = 2'd1;
  localparam logic [1:0] S_DM_BUSY = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [STREAK_W-1:0] streak;
  logic [TMR_W-1:0]    tmr;

  logic                grant_if;
  logic                grant_dm;
  logic                busy;
  logic                timeout_hit;
  logic                if_done;
  logic                dm_done;

  // State register: reset always lands in IDLE, even mid-transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and grant decision. Data wins unless fetch has already been
  // passed over DM_STREAK_MAX times in a row.
  always_comb begin
    state_next = state;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;
    case (state)
      S_IDLE: begin
        if (dm_req && !(if_req && (streak == STREAK_MAX))) begin
          grant_dm   = 1'b1;
          state_next = S_DM_BUSY;
        end else if (if_req) begin
          grant_if   = 1'b1;
          state_next = S_IF_BUSY;
        end
      end
      S_IF_BUSY, S_DM_BUSY: begin
        if (mem_ready || timeout_hit) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State-derived outputs and completion strobes. The memory request is
  // high for the whole time a transaction is in flight.
  always_comb begin
    busy        = (state == S_IF_BUSY) || (state == S_DM_BUSY);
    mem_req     = busy;
    timeout_hit = busy && !mem_ready && (tmr == TMR_LAST);
    if_done     = (state == S_IF_BUSY) && (mem_ready || timeout_hit);
    dm_done     = (state == S_DM_BUSY) && (mem_ready || timeout_hit);
  end

  // Memory-side register slice: captured at grant and held until the next grant
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_ctrl  <= CTRL_WORD;
    end else if (grant_if) begin
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
      mem_wdata <= '0;
      mem_ctrl  <= CTRL_WORD;
    end else if (grant_dm) begin
      mem_we    <= dm_we;
      mem_addr  <= dm_addr;
      mem_wdata <= dm_wdata;
      mem_ctrl  <= dm_ctrl;
    end
  end

  // Fairness streak: counts data grants made while a fetch was kept waiting
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (grant_if) begin
      streak <= '0;
    end else if (grant_dm) begin
      if (!if_req) begin
        streak <= '0;
      end else if (streak != STREAK_MAX) begin
        streak <= streak + STREAK_ONE;
      end
    end
  end

  // Watchdog: counts busy cycles spent waiting on the memory
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr <= '0;
    end else if (grant_if || grant_dm) begin
      tmr <= '0;
    end else if (busy && !mem_ready && (tmr != TMR_FULL)) begin
      tmr <= tmr + TMR_ONE;
    end
  end

  // Acks and read data. An aborted transaction returns zero. A store leaves
  // the previous load data in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_ack   <= 1'b0;
      dm_ack   <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_ack <= if_done;
      dm_ack <= dm_done;
      if (if_done) begin
        if_rdata <= timeout_hit ? 32'h0 : mem_rdata;
      end
      if (dm_done) begin
        if (timeout_hit) begin
          dm_rdata <= 32'h0;
        end else if (!mem_we) begin
          dm_rdata <= mem_rdata;
        end
      end
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      err_timeout <= 1'b0;
    end else if (timeout_hit) begin
      err_timeout <= 1'b1;
    end
  end

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = dm_req & ~dm_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench for mem_port_arbiter
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  dm_ctrl;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ctrl;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(
    .DM_STREAK_MAX(4),
    .TIMEOUT_CYC  (255)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_ack     (if_ack),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_ctrl    (dm_ctrl),
    .dm_ack     (dm_ack),
    .dm_rdata   (dm_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ctrl   (mem_ctrl),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .stall_if   (stall_if),
    .stall_mem  (stall_mem),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed 1ns after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req    = 1'b0;
    if_addr   = 32'h0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = 32'h0;
    dm_wdata  = 32'h0;
    dm_ctrl   = 3'b000;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_checks++; if (if_ack !== 1'b0 || dm_ack !== 1'b0) begin n_fail++; $display("FAIL reset_acks: got if=%b dm=%b want 0/0", if_ack, dm_ack); end
    n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_timeout); end
    n_checks++; if ({mem_we, mem_addr, mem_wdata, mem_ctrl} !== 68'h0) begin n_fail++; $display("FAIL reset_slice: got we=%b a=%h d=%h c=%b want zeros", mem_we, mem_addr, mem_wdata, mem_ctrl); end
    n_checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, dm_rdata); end
    n_checks++; if (stall_if !== 1'b0 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL reset_stalls: got %b/%b want 0/0", stall_if, stall_mem); end
    reset = 1'b0;
  endtask

  task automatic test_single_fetch();
    if_req  = 1'b1;
    if_addr = 32'h0000_0100;
    #1;
    n_checks++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL t1_stall_if: got %b want 1", stall_if); end
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_ctrl !== 3'b000) begin n_fail++; $display("FAIL t1_busy: got req=%b a=%h we=%b c=%b want 1/100/0/000", mem_req, mem_addr, mem_we, mem_ctrl); end
    n_checks++; if (if_ack !== 1'b0) begin n_fail++; $display("FAIL t1_early_ack: got %b want 0", if_ack); end
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    n_checks++; if (if_ack !== 1'b1 || if_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL t1_ack: got ack=%b d=%h want 1/deadbeef", if_ack, if_rdata); end
    n_checks++; if (mem_req !== 1'b0 || stall_if !== 1'b0) begin n_fail++; $display("FAIL t1_ackcyc: got req=%b stall=%b want 0/0", mem_req, stall_if); end
    if_req    = 1'b0;
    mem_ready = 1'b0;
    tick();
    n_checks++; if (if_ack !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL t1_after: got ack=%b req=%b want 0/0", if_ack, mem_req); end
  endtask

  task automatic test_ready_outside_busy();
    mem_ready = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    tick();
    tick();
    n_checks++; if (if_ack !== 1'b0 || dm_ack !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got if=%b dm=%b req=%b want 0/0/0", if_ack, dm_ack, mem_req); end
    n_checks++; if (if_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL idle_ready_rdata: got %h want deadbeef", if_rdata); end
    mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    if_req  = 1'b1;
    if_addr = 32'h0000_0200;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0000_0040;
    dm_ctrl = 3'b010;
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_ctrl !== 3'b010) begin n_fail++; $display("FAIL t2_dm_first: got req=%b a=%h c=%b want 1/40/010", mem_req, mem_addr, mem_ctrl); end
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_2222;
    tick();
    n_checks++; if (dm_ack !== 1'b1 || dm_rdata !== 32'h1111_2222 || if_ack !== 1'b0) begin n_fail++; $display("FAIL t2_dm_ack: got ack=%b d=%h ifack=%b want 1/11112222/0", dm_ack, dm_rdata, if_ack); end
    n_checks++; if (mem_req !== 1'b0 || stall_mem !== 1'b0 || stall_if !== 1'b1) begin n_fail++; $display("FAIL t2_gap: got req=%b sm=%b si=%b want 0/0/1", mem_req, stall_mem, stall_if); end
    dm_req    = 1'b0;
    mem_ready = 1'b0;
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || mem_ctrl !== 3'b000) begin n_fail++; $display("FAIL t2_if_grant: got req=%b a=%h c=%b want 1/200/000", mem_req, mem_addr, mem_ctrl); end
    mem_ready = 1'b1;
    mem_rdata = 32'h3333_4444;
    tick();
    n_checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h3333_4444 || dm_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL t2_if_ack: got ack=%b d=%h dd=%h want 1/33334444/11112222", if_ack, if_rdata, dm_rdata); end
    if_req    = 1'b0;
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_streak();
    logic        exp_if;
    logic [31:0] exp_addr;
    if_req  = 1'b1;
    if_addr = 32'h0000_0300;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0000_0050;
    dm_ctrl = 3'b000;
    for (int i = 0; i < 10; i++) begin
      exp_if   = (i == 4) || (i == 9);
      exp_addr = exp_if ? 32'h300 : 32'h50;
      tick();
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin n_fail++; $display("FAIL t3_grant%0d: got req=%b a=%h want 1/%h", i, mem_req, mem_addr, exp_addr); end
      mem_ready = 1'b1;
      mem_rdata = 32'h5000_0000 + i;
      tick();
      n_checks++; if (if_ack !== exp_if || dm_ack !== !exp_if || mem_req !== 1'b0) begin n_fail++; $display("FAIL t3_ack%0d: got if=%b dm=%b req=%b want %b/%b/0", i, if_ack, dm_ack, mem_req, exp_if, !exp_if); end
      mem_ready = 1'b0;
      if (i == 9) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
    end
    tick();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL t3_idle: got req=%b want 0", mem_req); end
  endtask

  task automatic test_store();
    // a load first so that dm_rdata holds a known value
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0000_0020;
    dm_ctrl = 3'b100;
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    n_checks++; if (dm_ack !== 1'b1 || dm_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL t4_load: got ack=%b d=%h want 1/cafef00d", dm_ack, dm_rdata); end
    dm_req    = 1'b0;
    mem_ready = 1'b0;
    tick();
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h0000_0010;
    dm_wdata = 32'hA5A5_A5A5;
    dm_ctrl  = 3'b010;
    for (int w = 0; w < 4; w++) begin
      tick();
      n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hA5A5_A5A5 || mem_ctrl !== 3'b010 || dm_ack !== 1'b0) begin n_fail++; $display("FAIL t4_hold%0d: got req=%b we=%b a=%h d=%h c=%b ack=%b want 1/1/10/a5a5a5a5/010/0", w, mem_req, mem_we, mem_addr, mem_wdata, mem_ctrl, dm_ack); end
      if (w == 0) begin
        // requester withdraws and the live inputs change under the latched slice
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 32'hFFFF_FFF0;
        dm_wdata = 32'h0;
      end
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h9999_9999;
    tick();
    n_checks++; if (dm_ack !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL t4_ack: got ack=%b req=%b want 1/0", dm_ack, mem_req); end
    n_checks++; if (dm_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL t4_rdata_kept: got %h want cafef00d", dm_rdata); end
    mem_ready = 1'b0;
    tick();
    n_checks++; if (dm_ack !== 1'b0) begin n_fail++; $display("FAIL t4_pulse: got %b want 0", dm_ack); end
  endtask

  task automatic test_timeout();
    int got_ack;
    int ack_cycle;
    int req_cycles;
    got_ack    = 0;
    ack_cycle  = 0;
    req_cycles = 0;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0400;
    mem_ready = 1'b0;
    mem_rdata = 32'h7777_7777;
    for (int c = 1; c <= 400 && got_ack == 0; c++) begin
      tick();
      if (if_ack === 1'b1) begin
        got_ack   = 1;
        ack_cycle = c;
      end else if (mem_req === 1'b1) begin
        req_cycles++;
      end
      if (c == 255) begin
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL t5_err_early: got %b want 0", err_timeout); end
      end
    end
    n_checks++; if (got_ack != 1 || ack_cycle != 256) begin n_fail++; $display("FAIL t5_ack_cycle: got ack=%0d at cycle %0d want ack at 256", got_ack, ack_cycle); end
    n_checks++; if (req_cycles != 255) begin n_fail++; $display("FAIL t5_req_len: got %0d want 255", req_cycles); end
    n_checks++; if (if_rdata !== 32'h0 || err_timeout !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL t5_abort: got d=%h err=%b req=%b want 0/1/0", if_rdata, err_timeout, mem_req); end
    if_req = 1'b0;
    tick();
    // a normal load afterwards leaves the error flag set
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0000_0030;
    dm_ctrl = 3'b000;
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    tick();
    n_checks++; if (dm_ack !== 1'b1 || dm_rdata !== 32'h0BAD_F00D || err_timeout !== 1'b1) begin n_fail++; $display("FAIL t5_sticky: got ack=%b d=%h err=%b want 1/0badf00d/1", dm_ack, dm_rdata, err_timeout); end
    dm_req    = 1'b0;
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0000_0060;
    tick();
    n_checks++; if (mem_req !== 1'b1 || err_timeout !== 1'b1) begin n_fail++; $display("FAIL t6_busy: got req=%b err=%b want 1/1", mem_req, err_timeout); end
    reset     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    n_checks++; if (mem_req !== 1'b0 || dm_ack !== 1'b0 || err_timeout !== 1'b0 || dm_rdata !== 32'h0) begin n_fail++; $display("FAIL t6_reset: got req=%b ack=%b err=%b d=%h want 0/0/0/0", mem_req, dm_ack, err_timeout, dm_rdata); end
    reset     = 1'b0;
    mem_ready = 1'b0;
    dm_req    = 1'b0;
    tick();
    n_checks++; if (mem_req !== 1'b0 || dm_ack !== 1'b0) begin n_fail++; $display("FAIL t6_idle: got req=%b ack=%b want 0/0", mem_req, dm_ack); end
    if_req  = 1'b1;
    if_addr = 32'h0000_0500;
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin n_fail++; $display("FAIL t6_regrant: got req=%b a=%h want 1/500", mem_req, mem_addr); end
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0ACE;
    tick();
    n_checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h0000_0ACE) begin n_fail++; $display("FAIL t6_fetch: got ack=%b d=%h want 1/00000ace", if_ack, if_rdata); end
    if_req    = 1'b0;
    mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_ready_outside_busy();
    test_back_to_back();
    test_streak();
    test_store();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
